wb_master: RTL and testbench

WB_MASTER -- requirements
Module: wb_master

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_master_if.sv | 48 ++++
 rtl/wb_master.sv | 98 +++++++++
 tb/tb_wb_master.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone command master: FSM state encoding
// and default bus widths.
package wb_pkg;

    localparam int WB_DATA_WIDTH_DEF = 8;
    localparam int WB_ADDR_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STROBE   = 2'd1,
        ST_WAIT_ACK = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_master_if.sv
// Command/response port plus Wishbone bus of the command master, bundled
// with a master modport (the block) and a slave modport (its environment).
interface wb_master_if import wb_pkg::*; #(
    parameter int WB_DATA_WIDTH = WB_DATA_WIDTH_DEF,
    parameter int WB_ADDR_WIDTH = WB_ADDR_WIDTH_DEF
);

    // A command transfers on a rising clk edge where cmd_valid_i and
    // cmd_ready_o are both high; the requester keeps its fields stable until
    // then, and ready never depends on valid.
    logic                     cmd_valid_i;
    logic                     cmd_ready_o;
    logic                     cmd_we_i;
    logic                     cmd_lock_i;
    logic [WB_ADDR_WIDTH-1:0] cmd_adr_i;
    logic [WB_DATA_WIDTH-1:0] cmd_dat_i;

    logic                     rsp_valid_o;
    logic [WB_DATA_WIDTH-1:0] rsp_dat_o;
    logic                     rsp_err_o;

    logic                     wb_cyc_o;
    logic                     wb_stb_o;
    logic                     wb_we_o;
    logic                     wb_lock_o;
    logic [WB_ADDR_WIDTH-1:0] wb_adr_o;
    logic [WB_DATA_WIDTH-1:0] wb_dat_o;
    logic                     wb_stall_i;
    logic                     wb_ack_i;
    logic [WB_DATA_WIDTH-1:0] wb_dat_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_lock_i, cmd_adr_i, cmd_dat_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_lock_o, wb_adr_o, wb_dat_o,
        input  wb_stall_i, wb_ack_i, wb_dat_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_lock_i, cmd_adr_i, cmd_dat_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_lock_o, wb_adr_o, wb_dat_o,
        output wb_stall_i, wb_ack_i, wb_dat_i
    );

endinterface

// File: rtl/wb_master.sv
// Single-transaction Wishbone (pipelined) master driven by a valid/ready command
// port. Optional ack timeout is enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master import wb_pkg::*; #(
    parameter int WB_DATA_WIDTH     = WB_DATA_WIDTH_DEF,
    parameter int WB_ADDR_WIDTH     = WB_ADDR_WIDTH_DEF,
    parameter int WB_TIMEOUT_CYCLES = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_master_if.master bus,
    output wb_state_e   state_o
);

    wb_state_e                state_q, state_d;
    logic                     we_q, lock_q;
    logic [WB_ADDR_WIDTH-1:0] adr_q;
    logic [WB_DATA_WIDTH-1:0] dat_q;
    logic                     rsp_valid_q, rsp_err_q;
    logic [WB_DATA_WIDTH-1:0] rsp_dat_q;
    logic                     busy, accept, timeout, done;

    assign busy            = (state_q != ST_IDLE);
    assign bus.cmd_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign accept          = bus.cmd_valid_i && bus.cmd_ready_o;
    // Ack is only meaningful while a cycle is open; an ack coinciding with
    // the timeout still completes normally.
    assign done            = busy && (bus.wb_ack_i || timeout);

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(WB_TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || accept) begin
            to_cnt_q <= '0;
        end else if (busy) begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
        end
    end

    // Counter holds the number of earlier busy cycles, so this fires on the
    // last allowed cycle of the transaction.
    assign timeout = busy && (to_cnt_q == CNT_W'(WB_TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept) state_d = ST_STROBE;
            ST_STROBE: begin
                if (done)                 state_d = ST_IDLE;
                else if (!bus.wb_stall_i) state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: if (done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            lock_q      <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= done;
            if (accept) begin
                we_q   <= bus.cmd_we_i;
                lock_q <= bus.cmd_lock_i;
                adr_q  <= bus.cmd_adr_i;
                dat_q  <= bus.cmd_dat_i;
            end
            if (done) begin
                rsp_dat_q <= (bus.wb_ack_i && !we_q) ? bus.wb_dat_i : '0;
                rsp_err_q <= !bus.wb_ack_i;
            end
        end
    end

    assign bus.wb_cyc_o    = busy;
    assign bus.wb_stb_o    = (state_q == ST_STROBE);
    assign bus.wb_we_o     = we_q;
    assign bus.wb_lock_o   = busy && lock_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_wb_master.sv
// Bench for wb_master: memory-backed slave model with random stall/ack
// timing, response scoreboard, and directed corner cases.
module tb_wb_master;
    import wb_pkg::*;

    localparam int DW = 8;
    localparam int AW = 16;

    typedef struct packed {
        logic          we;
        logic          lock;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } cmd_t;

    logic      clk = 1'b0;
    logic      rst;
    wb_state_e state;
    int unsigned cyc_cnt = 0;

    wb_master_if #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW)) bus ();

    wb_master #(
        .WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .WB_TIMEOUT_CYCLES(15)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .state_o(state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [DW:0]     exp_q[$];      // {err, dat}
    cmd_t            cmd_q[$];
    int unsigned     rsp_log[$];
    int              n_tests = 0;
    int              n_fail  = 0;
    int unsigned     rsp_cnt = 0;
    int unsigned     last_acc_cyc = 0;
    logic [DW-1:0]   ref_mem [logic [AW-1:0]];
    logic [DW-1:0]   slv_mem [logic [AW-1:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic logic [DW-1:0] mem_default(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return mem_default(a);
    endfunction

    function automatic logic [DW-1:0] slv_rd(input logic [AW-1:0] a);
        if (slv_mem.exists(a)) return slv_mem[a];
        return mem_default(a);
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ref_mem[a] = d;
        slv_mem[a] = d;
    endtask

    // ---------------- response monitor ----------------
    logic [DW:0] mon_e;
    always @(negedge clk) begin
        if (bus.rsp_valid_o === 1'b1) begin
            rsp_cnt++;
            rsp_log.push_back(cyc_cnt);
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_dat", 32'(bus.rsp_dat_o), 32'(mon_e[DW-1:0]));
                check("rsp_err", 32'(bus.rsp_err_o), 32'(mon_e[DW]));
            end
        end
    end

    // ---------------- slave model ----------------
    logic slv_en = 1'b0;
    logic fix_en = 1'b0;
    int   fix_stall = 0;
    int   fix_dly = 0;
    logic started = 1'b0;
    logic exp_stb = 1'b0;
    cmd_t cur = '0;
    int   stall_left = 0;
    int   ack_dly = 0;
    int   stb_n = 0;
    int   last_stb_n = 0;

    task automatic slave_ack();
        bus.wb_ack_i = 1'b1;
        if (bus.wb_we_o) slv_mem[bus.wb_adr_o] = bus.wb_dat_o;
        else             bus.wb_dat_i = slv_rd(bus.wb_adr_o);
        last_stb_n = stb_n;
    endtask

    always @(posedge clk) begin
        #1;
        if (slv_en) begin
            bus.wb_ack_i   = 1'b0;
            bus.wb_stall_i = 1'b0;
            bus.wb_dat_i   = DW'($urandom);
            if (bus.wb_cyc_o !== 1'b1) begin
                started = 1'b0;
                check("lock_idle", 32'(bus.wb_lock_o), 32'd0);
            end else begin
                if (!started) begin
                    started = 1'b1;
                    exp_stb = 1'b1;
                    stb_n   = 0;
                    if (cmd_q.size() == 0) check("bus_unexpected", 32'd1, 32'd0);
                    else cur = cmd_q.pop_front();
                    stall_left = fix_en ? fix_stall : $urandom_range(0, 3);
                    ack_dly    = fix_en ? fix_dly   : $urandom_range(0, 3);
                end
                check("wb_stb",  32'(bus.wb_stb_o),  32'(exp_stb));
                check("wb_adr",  32'(bus.wb_adr_o),  32'(cur.adr));
                check("wb_we",   32'(bus.wb_we_o),   32'(cur.we));
                check("wb_lock", 32'(bus.wb_lock_o), 32'(cur.lock));
                if (cur.we) check("wb_dat", 32'(bus.wb_dat_o), 32'(cur.dat));
                if (exp_stb) stb_n++;
                if (exp_stb && stall_left > 0) begin
                    stall_left--;
                    bus.wb_stall_i = 1'b1;
                    if (!fix_en && $urandom_range(0, 7) == 0) slave_ack();
                end else if (ack_dly == 0) begin
                    slave_ack();
                end else begin
                    ack_dly--;
                end
                if (exp_stb && !bus.wb_stall_i && !bus.wb_ack_i) exp_stb = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_raw(input logic we, input logic lock,
                             input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        int guard = 0;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_lock_i  = lock;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        while (bus.cmd_ready_o !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (bus.cmd_ready_o !== 1'b1) check("accept_timeout", 32'd0, 32'd1);
        last_acc_cyc = cyc_cnt;
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic send_cmd(input logic we, input logic lock,
                            input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        exp_q.push_back({1'b0, (we ? '0 : ref_rd(adr))});
        if (we) ref_mem[adr] = dat;
        cmd_q.push_back('{we: we, lock: lock, adr: adr, dat: dat});
        drive_raw(we, lock, adr, dat);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((exp_q.size() != 0 || bus.wb_cyc_o !== 1'b0) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) check("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    logic [AW-1:0] adr_pool [10] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                    16'h0005, 16'h0006, 16'h0007, 16'h8000, 16'hFFFF};
    int unsigned acc1, acc2, rsp_before;

    initial begin
        rst = 1'b1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_lock_i  = 1'b0;
        bus.cmd_adr_i   = '0;
        bus.cmd_dat_i   = '0;
        bus.wb_stall_i  = 1'b0;
        bus.wb_ack_i    = 1'b0;
        bus.wb_dat_i    = '0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
        check("rst_cyc",       32'(bus.wb_cyc_o),    32'd0);
        check("rst_stb",       32'(bus.wb_stb_o),    32'd0);
        check("rst_we",        32'(bus.wb_we_o),     32'd0);
        check("rst_lock",      32'(bus.wb_lock_o),   32'd0);
        check("rst_adr",       32'(bus.wb_adr_o),    32'd0);
        check("rst_dat",       32'(bus.wb_dat_o),    32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err_o),   32'd0);
        check("rst_rsp_dat",   32'(bus.rsp_dat_o),   32'd0);
        check("rst_state",     32'(state),           32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.cmd_ready_o), 32'd1);
        slv_en = 1'b1;

        // Read, slave acks on the first strobe cycle
        fix_en = 1'b1; fix_stall = 0; fix_dly = 0;
        preload(16'h0280, 8'h5A);
        send_cmd(1'b0, 1'b0, 16'h0280, 8'h00);
        wait_idle();
        check("read_stb_cycles", 32'(last_stb_n), 32'd1);
        check("read_latency", rsp_log[rsp_log.size()-1] - last_acc_cyc, 32'd2);
        repeat (3) @(negedge clk);
        check("rsp_dat_hold", 32'(bus.rsp_dat_o), 32'h5A);

        // Write held off by 3 stall cycles, ack 2 cycles after release
        fix_stall = 3; fix_dly = 2;
        send_cmd(1'b1, 1'b0, 16'h1000, 8'hC3);
        wait_idle();
        check("write_stb_cycles", 32'(last_stb_n), 32'd4);
        fix_stall = 0; fix_dly = 0;
        send_cmd(1'b0, 1'b1, 16'h1000, 8'h00);
        wait_idle();

        // Back-to-back reads with valid held high
        rsp_log.delete();
        send_cmd(1'b0, 1'b0, 16'h0000, 8'h00);
        acc1 = last_acc_cyc;
        send_cmd(1'b0, 1'b0, 16'h0001, 8'h00);
        acc2 = last_acc_cyc;
        wait_idle();
        check("b2b_second_accept", acc2, rsp_log[0]);
        check("b2b_first_latency", rsp_log[0] - acc1, 32'd2);
        check("b2b_second_latency", rsp_log[1] - acc2, 32'd2);

        // Spurious ack and stall while idle
        slv_en = 1'b0;
        rsp_before = rsp_cnt;
        @(negedge clk);
        bus.wb_ack_i = 1'b1; bus.wb_stall_i = 1'b1; bus.wb_dat_i = 8'hEE;
        @(negedge clk);
        bus.wb_ack_i = 1'b0; bus.wb_stall_i = 1'b0;
        repeat (3) @(negedge clk);
        check("spurious_no_rsp", rsp_cnt, rsp_before);
        check("spurious_state", 32'(state), 32'(ST_IDLE));
        check("spurious_ready", 32'(bus.cmd_ready_o), 32'd1);
        slv_en = 1'b1;

        // Randomized traffic against the memory model
        fix_en = 1'b0;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     adr_pool[$urandom_range(0, 9)], DW'($urandom));
        end
        wait_idle();

        // Slave never answers
        slv_en = 1'b0;
        bus.wb_ack_i = 1'b0; bus.wb_stall_i = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        begin
            int n = 0;
            exp_q.push_back({1'b1, 8'h00});
            drive_raw(1'b0, 1'b1, 16'h0004, 8'h00);
            @(negedge clk);
            while (bus.wb_cyc_o === 1'b1 && n < 100) begin
                n++;
                @(negedge clk);
            end
            check("timeout_cyc_cycles", 32'(n), 32'd15);
            wait_idle();
        end
`else
        drive_raw(1'b0, 1'b0, 16'h0004, 8'h00);
        repeat (100) @(negedge clk);
        check("no_timeout_cyc", 32'(bus.wb_cyc_o), 32'd1);
        check("no_timeout_err", 32'(bus.rsp_err_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("no_timeout_rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
`endif

        // Reset while waiting for ack, ack arrives right after
        rsp_before = rsp_cnt;
        drive_raw(1'b0, 1'b0, 16'h0005, 8'h00);
        @(negedge clk);
        check("rwa_stb_first", 32'(bus.wb_stb_o), 32'd1);
        @(negedge clk);
        check("rwa_state", 32'(state), 32'(ST_WAIT_ACK));
        check("rwa_cyc", 32'(bus.wb_cyc_o), 32'd1);
        check("rwa_stb", 32'(bus.wb_stb_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rwa_rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
        check("rwa_rst_ready", 32'(bus.cmd_ready_o), 32'd0);
        rst = 1'b0;
        bus.wb_ack_i = 1'b1; bus.wb_dat_i = 8'h77;
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        check("rwa_ready_after", 32'(bus.cmd_ready_o), 32'd1);
        repeat (3) @(negedge clk);
        check("rwa_no_rsp", rsp_cnt, rsp_before);
        check("rwa_idle_cyc", 32'(bus.wb_cyc_o), 32'd0);

        slv_en = 1'b1;
        send_cmd(1'b0, 1'b0, 16'h0006, 8'h00);
        wait_idle();

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
